// File: rtl/cnt_seq_checker.sv
// rtl/cnt_seq_checker.sv - counter sequence monitor: acquire, lock, flag and count out-of-sequence samples
// Optional CHK_RESYNC_EN: adopt the received value as the new phase on a locked mismatch.
module cnt_seq_checker #(
  parameter int W      = 3,
  parameter int STEP   = 1,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2,
  parameter int ECW    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  input  logic [W-1:0]   in_y,
  output logic           locked,
  output logic           err,
  output logic [ECW-1:0] err_cnt,
  output logic [W-1:0]   exp_y
);

  localparam int GCW = $clog2(LOCK_N + 1);
  localparam int MCW = $clog2(LOSS_N + 1);
  localparam logic [W-1:0]   STEP_W   = W'(STEP);
  localparam logic [GCW-1:0] LOCK_N_W = GCW'(LOCK_N);
  localparam logic [MCW-1:0] LOSS_N_W = MCW'(LOSS_N);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;
  logic [W-1:0]   exp_y_q, exp_y_d;
  logic [GCW-1:0] good_cnt_q, good_cnt_d;
  logic [MCW-1:0] miss_cnt_q, miss_cnt_d;

  logic match;
  assign match = (in_y == exp_y_q);

  always_comb begin
    state_d    = state_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    exp_y_d    = exp_y_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (in_vld) begin
      case (state_q)
        ST_SEARCH: begin
          exp_y_d    = in_y + STEP_W;
          good_cnt_d = '0;
          state_d    = ST_ACQ;
        end
        ST_ACQ: begin
          if (match) begin
            good_cnt_d = good_cnt_q + GCW'(1);
            exp_y_d    = exp_y_q + STEP_W;
            if (good_cnt_q + GCW'(1) == LOCK_N_W) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end
          end else begin
            // Restart the run from the value just received.
            exp_y_d    = in_y + STEP_W;
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            miss_cnt_d = '0;
            exp_y_d    = exp_y_q + STEP_W;
          end else begin
            err_d      = 1'b1;
            err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ECW'(1);
            miss_cnt_d = miss_cnt_q + MCW'(1);
`ifdef CHK_RESYNC_EN
            exp_y_d    = in_y + STEP_W;
`else
            exp_y_d    = exp_y_q + STEP_W;
`endif
            if (miss_cnt_q + MCW'(1) == LOSS_N_W) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              miss_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SEARCH;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      exp_y_q    <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      exp_y_q    <= exp_y_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign exp_y   = exp_y_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb/tb_cnt_seq_checker.sv - directed self-checking bench for cnt_seq_checker (default and ECW=2 instances)
module tb_cnt_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vld = 1'b0;
  logic [2:0] in_y = 3'd0;

  logic       locked_a, err_a;
  logic [7:0] err_cnt_a;
  logic [2:0] exp_y_a;
  logic       locked_b, err_b;
  logic [1:0] err_cnt_b;
  logic [2:0] exp_y_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnt_seq_checker dut_a (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_y(in_y),
    .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a), .exp_y(exp_y_a)
  );

  cnt_seq_checker #(.ECW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_y(in_y),
    .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b), .exp_y(exp_y_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int lk, input int er, input int cnt, input int ex);
    check({tag, " locked"},    int'(locked_a),  lk);
    check({tag, " err"},       int'(err_a),     er);
    check({tag, " err_cnt"},   int'(err_cnt_a), cnt);
    check({tag, " exp_y"},     int'(exp_y_a),   ex);
    check({tag, " b.locked"},  int'(locked_b),  lk);
    check({tag, " b.err"},     int'(err_b),     er);
    check({tag, " b.err_cnt"}, int'(err_cnt_b), (cnt > 3) ? 3 : cnt);
    check({tag, " b.exp_y"},   int'(exp_y_b),   ex);
  endtask

  task automatic step(input string tag, input logic vld, input int y,
                      input int lk, input int er, input int cnt, input int ex);
    in_vld = vld;
    in_y   = 3'(y);
    @(posedge clk);
    #1;
    check_all(tag, lk, er, cnt, ex);
  endtask

  initial begin
    #2;
    rst_n = 1'b0; in_vld = 1'b1; in_y = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    step("acq5",  1, 5, 0, 0, 0, 6);
    step("acq6",  1, 6, 0, 0, 0, 7);
    step("acq7",  1, 7, 0, 0, 0, 0);
    step("acq0",  1, 0, 0, 0, 0, 1);
    step("lock1", 1, 1, 1, 0, 0, 2);
    step("lock2", 1, 2, 1, 0, 0, 3);

    step("gap0",  0, 2, 1, 0, 0, 3);
    step("gap1",  1, 3, 1, 0, 0, 4);
    step("gap2",  0, 3, 1, 0, 0, 4);
    step("gap3",  1, 4, 1, 0, 0, 5);

    step("gl6a",  1, 6, 1, 1, 1, 6);
    step("gl6b",  1, 6, 1, 0, 1, 7);
    step("gl7",   1, 7, 1, 0, 1, 0);
    step("gl3",   1, 3, 1, 1, 2, 1);
    step("glgap", 0, 3, 1, 0, 2, 1);
    step("gl1",   1, 1, 1, 0, 2, 2);

    step("loss1", 1, 5, 1, 1, 3, 3);
    step("loss2", 1, 5, 0, 1, 4, 4);
    step("srch0", 1, 0, 0, 0, 4, 1);
    step("acqmm", 1, 5, 0, 0, 4, 6);
    step("re6",   1, 6, 0, 0, 4, 7);
    step("re7",   1, 7, 0, 0, 4, 0);
    step("re0",   1, 0, 0, 0, 4, 1);
    step("re1",   1, 1, 1, 0, 4, 2);

    step("sat_e1", 1, 6, 1, 1, 5, 3);
    step("sat_m1", 1, 3, 1, 0, 5, 4);
    step("sat_e2", 1, 0, 1, 1, 6, 5);
    step("sat_m2", 1, 5, 1, 0, 6, 6);
    step("sat_e3", 1, 2, 1, 1, 7, 7);
    step("sat_m3", 1, 7, 1, 0, 7, 0);

    rst_n = 1'b0; in_vld = 1'b1; in_y = 3'd0;
    @(posedge clk);
    #1;
    check_all("midrst", 0, 0, 0, 0);
    rst_n = 1'b1;
    step("post",  1, 3, 0, 0, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
